// File: rtl/wrr_pkg.sv
// Shared definitions for the weighted round-robin arbiter and its requester.
package wrr_pkg;

  localparam int CHANNELS     = 8;
  localparam int WIDTH        = 32;
  localparam int DEPTH        = 16;
  localparam int WEIGHT_LIMIT = 16;

  localparam int CHAN_W = $clog2(CHANNELS);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef logic [CHAN_W-1:0] chan_idx_t;
  typedef logic [WIDTH-1:0]  weight_t;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [CHANNELS-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      ones = ones + int'(v[i]);
    end
    return (ones == 1);
  endfunction

  // Binary index of a one-hot vector; result is meaningless if v is not one-hot.
  function automatic chan_idx_t onehot_to_idx(input logic [CHANNELS-1:0] v);
    chan_idx_t idx;
    idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (v[i]) begin
        idx = idx | chan_idx_t'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_chan_ctr.sv
// Single-channel pending-transaction counter, saturating at DEPTH.
module wrr_chan_ctr #(
  parameter int DEPTH = wrr_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc,
  input  logic                     dec,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     nonzero,
  output logic                     ovf
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count_reg;
  logic             full;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign count   = count_reg;
  assign nonzero = (count_reg != '0);
  // A simultaneous inc/dec cancels, so a full channel never overflows then.
  assign ovf     = inc && !dec && full;

  // Count update: inc and dec together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (inc && !dec) begin
      if (!full) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end else if (dec && !inc && nonzero) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/wrr_req_source.sv
// Requester side of the WRR arbiter: per-channel pending counts drive the
// request vector, legal grants retire transactions, weights are programmable.
module wrr_req_source #(
  parameter int CHANNELS     = wrr_pkg::CHANNELS,
  parameter int WIDTH        = wrr_pkg::WIDTH,
  parameter int DEPTH        = wrr_pkg::DEPTH,
  parameter int WEIGHT_LIMIT = wrr_pkg::WEIGHT_LIMIT
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [CHANNELS-1:0]                    enq,
  output logic [CHANNELS-1:0]                    request,
  input  logic [CHANNELS-1:0]                    grant1,
  output logic [CHANNELS*WIDTH-1:0]              weight,
  input  logic                                   cfg_we,
  input  logic [$clog2(CHANNELS)-1:0]            cfg_ch,
  input  logic [WIDTH-1:0]                       cfg_wdata,
  output logic                                   gnt_valid,
  output logic [$clog2(CHANNELS)-1:0]            gnt_id,
  output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]  pend_cnt_flat,
  output logic [CHANNELS-1:0]                    ovf_err,
  output logic                                   proto_err,
  output logic [CHANNELS-1:0]                    err_ch,
  input  logic                                   err_clr
);

  import wrr_pkg::*;

  localparam int CW     = $clog2(CHANNELS);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic [CHANNELS-1:0] nonzero;
  logic [CHANNELS-1:0] dec;
  logic [CHANNELS-1:0] ovf_pulse;
  logic                grant_legal;
  logic                grant_illegal;
  logic [WIDTH-1:0]    wr_value;
  logic                cfg_in_range;

  logic [WIDTH-1:0]    weight_reg [CHANNELS];
  logic                gnt_valid_reg;
  logic [CW-1:0]       gnt_id_reg;
  logic [CHANNELS-1:0] ovf_err_reg;
  logic                proto_err_reg;
  logic [CHANNELS-1:0] err_ch_reg;

  assign request = nonzero;

  // Grant legality: exactly one bit, and it must hit a channel with work pending.
  always_comb begin
    grant_legal   = is_onehot(grant1) && ((grant1 & nonzero) != '0);
    grant_illegal = (grant1 != '0) && !grant_legal;
    dec           = grant_legal ? grant1 : '0;
  end

  // Clamp the programmed weight into 1..WEIGHT_LIMIT.
  always_comb begin
    cfg_in_range = (int'(cfg_ch) < CHANNELS);
    if (cfg_wdata == '0) begin
      wr_value = WIDTH'(1);
    end else if (cfg_wdata > WIDTH'(WEIGHT_LIMIT)) begin
      wr_value = WIDTH'(WEIGHT_LIMIT);
    end else begin
      wr_value = cfg_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      wrr_chan_ctr #(.DEPTH(DEPTH)) u_ctr (
        .clk     (clk),
        .reset   (reset),
        .inc     (enq[gi]),
        .dec     (dec[gi]),
        .count   (pend_cnt_flat[gi*CNT_W +: CNT_W]),
        .nonzero (nonzero[gi]),
        .ovf     (ovf_pulse[gi])
      );

      // Per-channel weight register, reset to the minimum legal weight.
      always_ff @(posedge clk) begin
        if (reset) begin
          weight_reg[gi] <= WIDTH'(1);
        end else if (cfg_we && cfg_in_range && (cfg_ch == CW'(gi))) begin
          weight_reg[gi] <= wr_value;
        end
      end

      assign weight[gi*WIDTH +: WIDTH] = weight_reg[gi];
    end
  endgenerate

  // Grant event reporting and sticky error capture; a new error beats err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_valid_reg <= 1'b0;
      gnt_id_reg    <= '0;
      ovf_err_reg   <= '0;
      proto_err_reg <= 1'b0;
      err_ch_reg    <= '0;
    end else begin
      gnt_valid_reg <= grant_legal;
      if (grant_legal) begin
        gnt_id_reg <= onehot_to_idx(grant1);
      end
      ovf_err_reg   <= (err_clr ? '0 : ovf_err_reg) | ovf_pulse;
      proto_err_reg <= (err_clr ? 1'b0 : proto_err_reg) | grant_illegal;
      if (grant_illegal && (!proto_err_reg || err_clr)) begin
        err_ch_reg <= grant1;
      end else if (err_clr) begin
        err_ch_reg <= '0;
      end
    end
  end

  assign gnt_valid = gnt_valid_reg;
  assign gnt_id    = gnt_id_reg;
  assign ovf_err   = ovf_err_reg;
  assign proto_err = proto_err_reg;
  assign err_ch    = err_ch_reg;

endmodule

// File: tb/tb_wrr_req_source.sv
// Self-checking bench for wrr_req_source with a grant scoreboard.
module tb_wrr_req_source;

  localparam int NCH = 8;
  localparam int W   = 32;
  localparam int CW  = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   enq = '0;
  logic [NCH-1:0]   grant1 = '0;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_ch = '0;
  logic [W-1:0]     cfg_wdata = '0;
  logic             err_clr = 1'b0;
  logic [NCH-1:0]   request;
  logic [NCH*W-1:0] weight;
  logic             gnt_valid;
  logic [2:0]       gnt_id;
  logic [NCH*CW-1:0] pend_cnt_flat;
  logic [NCH-1:0]   ovf_err;
  logic             proto_err;
  logic [NCH-1:0]   err_ch;

  wrr_req_source dut (
    .clk(clk), .reset(reset), .enq(enq), .request(request), .grant1(grant1),
    .weight(weight), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_wdata(cfg_wdata),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .pend_cnt_flat(pend_cnt_flat),
    .ovf_err(ovf_err), .proto_err(proto_err), .err_ch(err_ch), .err_clr(err_clr)
  );

  initial forever #5 clk = ~clk;

  int tests_run = 0;
  int failures  = 0;
  int model_cnt [NCH];
  int exp_q [$];
  int gnt_seen = 0;
  int accepted = 0;

  // Scoreboard: every gnt_valid pulse must match the oldest expected grant.
  always @(negedge clk) begin
    int e;
    if (!reset && gnt_valid) begin
      gnt_seen++;
      tests_run++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL gnt_unexpected: gnt_id=%0d, required no gnt_valid", gnt_id);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] gnt event id=%0d", gnt_id);
        if (int'(gnt_id) !== e) begin
          failures++;
          $display("FAIL gnt_id: got %0d, required %0d", gnt_id, e);
        end
      end
    end
  end

  function automatic int pend(input int ch);
    return int'(pend_cnt_flat[ch*CW +: CW]);
  endfunction

  // Drive one cycle of enq/grant and advance the reference model.
  task automatic do_cycle(input logic [NCH-1:0] e, input logic [NCH-1:0] g);
    int ones = 0;
    int idx = 0;
    bit legal;
    for (int i = 0; i < NCH; i++) if (g[i]) begin ones++; idx = i; end
    legal = (ones == 1) && (model_cnt[idx] != 0);
    for (int i = 0; i < NCH; i++) begin
      bit inc = e[i];
      bit dc  = legal && g[i];
      if (inc && !dc) begin
        if (model_cnt[i] < 16) begin model_cnt[i]++; accepted++; end
      end else if (inc && dc) begin
        accepted++;
      end else if (dc) begin
        model_cnt[i]--;
      end
    end
    if (legal) exp_q.push_back(idx);
    enq = e;
    grant1 = g;
    @(posedge clk); #1;
    enq = '0;
    grant1 = '0;
  endtask

  task automatic do_reset(input int n, input bit noise);
    reset = 1'b1;
    if (noise) begin
      enq = 8'($urandom_range(0, 255));
      grant1 = 8'($urandom_range(0, 255));
    end
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b0;
    enq = '0;
    grant1 = '0;
    for (int i = 0; i < NCH; i++) model_cnt[i] = 0;
    exp_q.delete();
    gnt_seen = 0;
    accepted = 0;
  endtask

  task automatic do_clear();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic write_w(input logic [2:0] ch, input logic [W-1:0] d);
    cfg_we = 1'b1; cfg_ch = ch; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (request !== 8'h00) begin failures++; $display("FAIL rst_request: got %h, required 00", request); end
    for (int i = 0; i < NCH; i++) begin
      tests_run++;
      if (weight[i*W +: W] !== 32'd1) begin
        failures++; $display("FAIL rst_weight%0d: got %0d, required 1", i, weight[i*W +: W]);
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if ({gnt_valid, gnt_id, ovf_err, proto_err, err_ch} !== '0) begin
      failures++; $display("FAIL rst_status: got %b/%0d/%h/%b/%h, required all zero", gnt_valid, gnt_id, ovf_err, proto_err, err_ch);
    end
    tests_run++;
    if (request !== 8'h00) begin failures++; $display("FAIL rst_request2: got %h, required 00", request); end
    reset = 1'b0;
    for (int i = 0; i < NCH; i++) model_cnt[i] = 0;
    do_cycle(8'h05, 8'h00);
    tests_run++;
    if (request !== 8'h05) begin failures++; $display("FAIL rst_enq_request: got %h, required 05", request); end
  endtask

  task automatic test_grant_retire();
    int seen0;
    do_reset(1, 1'b0);
    repeat (3) do_cycle(8'h04, 8'h00);
    tests_run++;
    if (pend(2) !== 3) begin failures++; $display("FAIL retire_cnt3: got %0d, required 3", pend(2)); end
    seen0 = gnt_seen;
    for (int k = 0; k < 3; k++) begin
      do_cycle(8'h00, 8'h04);
      tests_run++;
      if (gnt_valid !== 1'b1 || gnt_id !== 3'd2) begin
        failures++; $display("FAIL retire_gnt%0d: got valid=%b id=%0d, required valid=1 id=2", k, gnt_valid, gnt_id);
      end
      tests_run++;
      if (request[2] !== (k < 2)) begin
        failures++; $display("FAIL retire_req%0d: got %b, required %b", k, request[2], (k < 2));
      end
    end
    do_cycle(8'h00, 8'h00);
    tests_run++;
    if (gnt_valid !== 1'b0 || pend(2) !== 0) begin
      failures++; $display("FAIL retire_end: got valid=%b cnt=%0d, required 0/0", gnt_valid, pend(2));
    end
    tests_run++;
    if (gnt_seen - seen0 !== 3) begin failures++; $display("FAIL retire_pulses: got %0d, required 3", gnt_seen - seen0); end
    tests_run++;
    if (proto_err !== 1'b0 || ovf_err !== 8'h00) begin
      failures++; $display("FAIL retire_err: got proto=%b ovf=%h, required 0/00", proto_err, ovf_err);
    end
  endtask

  task automatic test_overflow();
    do_reset(1, 1'b0);
    repeat (16) do_cycle(8'h80, 8'h00);
    tests_run++;
    if (pend(7) !== 16 || ovf_err !== 8'h00) begin
      failures++; $display("FAIL ovf_at16: got cnt=%0d ovf=%h, required 16/00", pend(7), ovf_err);
    end
    do_cycle(8'h80, 8'h00);
    tests_run++;
    if (pend(7) !== 16 || ovf_err !== 8'h80) begin
      failures++; $display("FAIL ovf_sat: got cnt=%0d ovf=%h, required 16/80", pend(7), ovf_err);
    end
    do_cycle(8'h80, 8'h80);
    tests_run++;
    if (pend(7) !== 16 || ovf_err !== 8'h80 || proto_err !== 1'b0 || gnt_valid !== 1'b1) begin
      failures++; $display("FAIL ovf_enq_gnt: got cnt=%0d ovf=%h proto=%b gv=%b, required 16/80/0/1", pend(7), ovf_err, proto_err, gnt_valid);
    end
    do_clear();
    tests_run++;
    if (ovf_err !== 8'h00) begin failures++; $display("FAIL ovf_clr: got %h, required 00", ovf_err); end
  endtask

  task automatic test_illegal();
    do_reset(1, 1'b0);
    do_cycle(8'h03, 8'h00);
    do_cycle(8'h00, 8'h03);
    tests_run++;
    if (proto_err !== 1'b1 || err_ch !== 8'h03) begin
      failures++; $display("FAIL ill_multi: got proto=%b err_ch=%h, required 1/03", proto_err, err_ch);
    end
    tests_run++;
    if (gnt_valid !== 1'b0 || pend(0) !== 1 || pend(1) !== 1) begin
      failures++; $display("FAIL ill_multi_cnt: got gv=%b c0=%0d c1=%0d, required 0/1/1", gnt_valid, pend(0), pend(1));
    end
    do_cycle(8'h00, 8'h10);
    tests_run++;
    if (proto_err !== 1'b1 || err_ch !== 8'h03 || gnt_valid !== 1'b0 || pend(4) !== 0) begin
      failures++; $display("FAIL ill_idle: got proto=%b err_ch=%h gv=%b c4=%0d, required 1/03/0/0", proto_err, err_ch, gnt_valid, pend(4));
    end
    do_clear();
    tests_run++;
    if (proto_err !== 1'b0 || err_ch !== 8'h00) begin
      failures++; $display("FAIL ill_clr: got proto=%b err_ch=%h, required 0/00", proto_err, err_ch);
    end
  endtask

  task automatic test_weights();
    logic [W-1:0] req_tab [5] = '{32'd16, 32'd1, 32'd9, 32'd16, 32'd16};
    logic [W-1:0] dat_tab [5] = '{32'd40, 32'd0, 32'd9, 32'd16, 32'd17};
    logic [2:0]   ch_tab  [5] = '{3'd3, 3'd3, 3'd3, 3'd5, 3'd5};
    do_reset(1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      write_w(ch_tab[k], dat_tab[k]);
      tests_run++;
      if (weight[ch_tab[k]*W +: W] !== req_tab[k]) begin
        failures++; $display("FAIL weight_wr%0d: got %0d, required %0d", k, weight[ch_tab[k]*W +: W], req_tab[k]);
      end
    end
    // With 8 channels every 3-bit index is in range; exercise a strobe-less cycle instead.
    cfg_ch = 3'd3; cfg_wdata = 32'd5;
    @(posedge clk); #1;
    tests_run++;
    if (weight[3*W +: W] !== 32'd9 || weight[0 +: W] !== 32'd1) begin
      failures++; $display("FAIL weight_nowe: got w3=%0d w0=%0d, required 9/1", weight[3*W +: W], weight[0 +: W]);
    end
  endtask

  task automatic epoch_check(input string tag);
    int residual = 0;
    do_cycle(8'h00, 8'h00);
    for (int i = 0; i < NCH; i++) residual += model_cnt[i];
    tests_run++;
    if (gnt_seen !== accepted - residual) begin
      failures++; $display("FAIL soak_conserve_%s: got %0d pulses, required %0d", tag, gnt_seen, accepted - residual);
    end
  endtask

  task automatic test_soak();
    logic [NCH-1:0]    e, g, exp_req, cnt_req;
    logic [NCH*CW-1:0] exp_flat;
    int cand [$];
    do_reset(1, 1'b0);
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 99) == 0) begin
        epoch_check("pre_reset");
        do_reset(int'($urandom_range(1, 2)), 1'b1);
      end
      e = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      g = '0;
      cand.delete();
      for (int i = 0; i < NCH; i++) if (model_cnt[i] != 0) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 3) != 0)
        g[cand[$urandom_range(0, cand.size() - 1)]] = 1'b1;
      do_cycle(e, g);
      for (int i = 0; i < NCH; i++) begin
        exp_flat[i*CW +: CW] = 5'(model_cnt[i]);
        exp_req[i] = (model_cnt[i] != 0);
        cnt_req[i] = (pend_cnt_flat[i*CW +: CW] != '0);
      end
      tests_run++;
      if (pend_cnt_flat !== exp_flat) begin
        failures++; $display("FAIL soak_cnt@%0d: got %h, required %h", cyc, pend_cnt_flat, exp_flat);
      end
      tests_run++;
      if (request !== exp_req || request !== cnt_req) begin
        failures++; $display("FAIL soak_req@%0d: got %h, required %h (from counts %h)", cyc, request, exp_req, cnt_req);
      end
    end
    epoch_check("end");
    tests_run++;
    if (proto_err !== 1'b0) begin failures++; $display("FAIL soak_proto: got %b, required 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_grant_retire();
    test_overflow();
    test_illegal();
    test_weights();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
